pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Detects load-use hazards and accepts redirect events: jump resolved in ID, branch misprediction corrected in EX.
- Accepts halt/resume requests.
- Drives PC write-enable and IF/ID and ID/EX enable/flush controls.
- Keeps saturating performance counters for the FPGA debug display.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 15 +
 rtl/pipe_hazard_ctrl_if.sv | 31 +++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller
// and its hazard detection logic.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         MAX_FLUSH = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle: hazard/redirect requests into the
// controller and stage enable/flush controls back out.
interface pipe_hazard_ctrl_if;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       jmp;
  logic       br_mispred;
  logic       halt;
  logic       resume;
  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       halted;

  modport master (
    output ex_mem_read, ex_rt, id_rs, id_rt, id_use_rs, id_use_rt,
           jmp, br_mispred, halt, resume,
    input  pc_en, ifid_en, ifid_flush, idex_flush, halted
  );

  modport slave (
    input  ex_mem_read, ex_rt, id_rs, id_rt, id_use_rs, id_use_rt,
           jmp, br_mispred, halt, resume,
    output pc_en, ifid_en, ifid_flush, idex_flush, halted
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard check between the load in EX and the
// source operands of the instruction in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       use_rs,
  input  logic       use_rt,
  output logic       lu
);

  // $zero is never a real dependency, so a load targeting it cannot stall.
  assign lu = mem_read && (ex_rt != REG_ZERO) &&
              ((use_rs && (rs == ex_rt)) || (use_rt && (rt == ex_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with saturating
// performance counters for the debug display.
//
// state    | meaning
// RUN      | normal issue; redirects, halt and load-use stalls accepted
// LU_STALL | single bubble cycle after a load-use stall
// FLUSH    | extra IF/ID bubbles after a redirect (FLUSH_CYCLES > 1)
// HALT     | pipeline frozen until resume or a correcting mispredict
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  pipe_hazard_ctrl_if.slave bus,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] FC_LOAD = 2'(FLUSH_CYCLES - 1);

  state_t     state, state_next;
  logic [1:0] fc, fc_next;
  logic       lu;
  logic       stall_inc, flush_inc;
  state_t     redirect_state;

  hazard_detect u_hazard_detect (
    .mem_read (bus.ex_mem_read),
    .ex_rt    (bus.ex_rt),
    .rs       (bus.id_rs),
    .rt       (bus.id_rt),
    .use_rs   (bus.id_use_rs),
    .use_rt   (bus.id_use_rt),
    .lu       (lu)
  );

  // A single-cycle redirect is fully covered by the bubble issued in the
  // accepting cycle, so FLUSH is only entered for longer flushes.
  assign redirect_state = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      fc    <= 2'd0;
    end else begin
      state <= state_next;
      fc    <= fc_next;
    end
  end

  always_comb begin
    state_next = state;
    fc_next    = fc;
    if (en) begin
      case (state)
        RUN: begin
          if (bus.br_mispred || bus.jmp) begin
            state_next = redirect_state;
            fc_next    = FC_LOAD;
          end else if (bus.halt) begin
            state_next = HALT;
          end else if (lu) begin
            state_next = LU_STALL;
          end
        end
        LU_STALL, HALT: begin
          if (bus.br_mispred) begin
            state_next = redirect_state;
            fc_next    = FC_LOAD;
          end else if (state == LU_STALL || bus.resume) begin
            state_next = RUN;
          end
        end
        FLUSH: begin
          if (bus.br_mispred) begin
            fc_next = FC_LOAD;
          end else if (fc <= 2'd1) begin
            fc_next    = 2'd0;
            state_next = RUN;
          end else begin
            fc_next = fc - 2'd1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_comb begin
    bus.pc_en      = 1'b1;
    bus.ifid_en    = 1'b1;
    bus.ifid_flush = 1'b0;
    bus.idex_flush = 1'b0;
    bus.halted     = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    if (!rst) begin
      bus.pc_en      = 1'b0;
      bus.ifid_en    = 1'b0;
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (!en) begin
      bus.pc_en   = 1'b0;
      bus.ifid_en = 1'b0;
      bus.halted  = (state == HALT);
    end else begin
      case (state)
        RUN: begin
          if (bus.br_mispred) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
            flush_inc      = 1'b1;
          end else if (bus.jmp) begin
            bus.ifid_flush = 1'b1;
            flush_inc      = 1'b1;
          end else if (bus.halt) begin
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.idex_flush = 1'b1;
          end else if (lu) begin
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.idex_flush = 1'b1;
            stall_inc      = 1'b1;
          end
        end
        FLUSH: begin
          bus.ifid_flush = 1'b1;
          if (bus.br_mispred) begin
            bus.idex_flush = 1'b1;
            flush_inc      = 1'b1;
          end
        end
        LU_STALL, HALT: begin
          if (bus.br_mispred) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
            flush_inc      = 1'b1;
          end else if (state == HALT) begin
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.idex_flush = 1'b1;
            bus.halted     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (en) begin
      if (state != HALT && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
      if (stall_inc && stall_cnt != '1)     stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && flush_cnt != '1)     flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: dut_a (FLUSH_CYCLES=1, CNT_W=32) and dut_b
// (FLUSH_CYCLES=3, CNT_W=4) share one stimulus set.
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst, en;
  logic       ex_mem_read, id_use_rs, id_use_rt, jmp, br_mispred, halt, resume;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic [31:0] cyc_a, stl_a, fls_a;
  logic [3:0]  cyc_b, stl_b, fls_b;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus_a ();
  pipe_hazard_ctrl_if bus_b ();

  assign bus_a.ex_mem_read = ex_mem_read;  assign bus_b.ex_mem_read = ex_mem_read;
  assign bus_a.ex_rt       = ex_rt;        assign bus_b.ex_rt       = ex_rt;
  assign bus_a.id_rs       = id_rs;        assign bus_b.id_rs       = id_rs;
  assign bus_a.id_rt       = id_rt;        assign bus_b.id_rt       = id_rt;
  assign bus_a.id_use_rs   = id_use_rs;    assign bus_b.id_use_rs   = id_use_rs;
  assign bus_a.id_use_rt   = id_use_rt;    assign bus_b.id_use_rt   = id_use_rt;
  assign bus_a.jmp         = jmp;          assign bus_b.jmp         = jmp;
  assign bus_a.br_mispred  = br_mispred;   assign bus_b.br_mispred  = br_mispred;
  assign bus_a.halt        = halt;         assign bus_b.halt        = halt;
  assign bus_a.resume      = resume;       assign bus_b.resume      = resume;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .en(en), .bus(bus_a),
    .cycle_cnt(cyc_a), .stall_cnt(stl_a), .flush_cnt(fls_a)
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .bus(bus_b),
    .cycle_cnt(cyc_b), .stall_cnt(stl_b), .flush_cnt(fls_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    ex_mem_read = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
    id_use_rs = 0; id_use_rt = 0; jmp = 0; br_mispred = 0;
    halt = 0; resume = 0;
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset both DUTs and release with en=0 so no cycle is counted yet.
  task automatic do_reset();
    en = 0;
    clear_in();
    rst = 0;
    #2;
    @(negedge clk);
    rst = 1;
    tick();
  endtask

  initial begin
    rst = 0; en = 0;
    clear_in();
    #1;
    chk("rst_pc_en", bus_a.pc_en, 0);
    chk("rst_ifid_en", bus_a.ifid_en, 0);
    chk("rst_ifid_flush", bus_a.ifid_flush, 1);
    chk("rst_idex_flush", bus_a.idex_flush, 1);
    chk("rst_halted", bus_a.halted, 0);
    chk("rst_cyc", cyc_a, 0);
    chk("rst_fls_b", fls_b, 0);
    do_reset();

    // Load-use via rs, then ex_rt=0 (no stall), then via rt
    en = 1; ex_mem_read = 1; ex_rt = 3; id_rs = 3; id_use_rs = 1;
    #1;
    chk("lu_pc_en", bus_a.pc_en, 0);
    chk("lu_ifid_en", bus_a.ifid_en, 0);
    chk("lu_idex_flush", bus_a.idex_flush, 1);
    chk("lu_ifid_flush", bus_a.ifid_flush, 0);
    tick();
    #1;
    chk("lus_pc_en", bus_a.pc_en, 1);
    chk("lus_idex_flush", bus_a.idex_flush, 0);
    chk("lus_stall_cnt", stl_a, 1);
    tick();
    ex_rt = 0; id_rs = 0;
    #1;
    chk("lu0_pc_en", bus_a.pc_en, 1);
    chk("lu0_idex_flush", bus_a.idex_flush, 0);
    tick();
    chk("lu0_stall_cnt", stl_a, 1);
    chk("lu_cycle_cnt", cyc_a, 3);
    id_use_rs = 0; id_use_rt = 1; id_rt = 7; ex_rt = 7;
    #1;
    chk("lurt_pc_en", bus_a.pc_en, 0);
    tick();
    chk("lurt_stall_cnt", stl_a, 2);
    clear_in();

    // Jump held two cycles, FLUSH_CYCLES=1
    do_reset();
    en = 1; jmp = 1;
    #1;
    chk("j1_ifid_flush", bus_a.ifid_flush, 1);
    chk("j1_idex_flush", bus_a.idex_flush, 0);
    chk("j1_pc_en", bus_a.pc_en, 1);
    tick();
    chk("j2_ifid_flush", bus_a.ifid_flush, 1);
    tick();
    chk("j2_flush_cnt", fls_a, 2);
    jmp = 0;

    // Single jump pulse, FLUSH_CYCLES=3; second jmp lands in FLUSH and is ignored
    do_reset();
    en = 1; jmp = 1;
    #1;
    chk("b_j_c1", bus_b.ifid_flush, 1);
    tick();
    chk("b_j_c2", bus_b.ifid_flush, 1);
    chk("b_j_c2_idex", bus_b.idex_flush, 0);
    tick();
    jmp = 0;
    #1;
    chk("b_j_c3", bus_b.ifid_flush, 1);
    tick();
    chk("b_j_c4", bus_b.ifid_flush, 0);
    chk("b_j_flush_cnt", fls_b, 1);

    // br_mispred, jmp and load-use together
    do_reset();
    en = 1; br_mispred = 1; jmp = 1;
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_use_rs = 1;
    #1;
    chk("sim_ifid_flush", bus_a.ifid_flush, 1);
    chk("sim_idex_flush", bus_a.idex_flush, 1);
    chk("sim_pc_en", bus_a.pc_en, 1);
    tick();
    chk("sim_stall_cnt", stl_a, 0);
    chk("sim_flush_cnt", fls_a, 1);
    clear_in();

    // Halt, mispredict out of HALT, then halt/resume
    do_reset();
    en = 1; halt = 1;
    #1;
    chk("h_pc_en", bus_a.pc_en, 0);
    chk("h_halted_same", bus_a.halted, 0);
    tick();
    halt = 0;
    #1;
    chk("h_halted", bus_a.halted, 1);
    chk("h_hold_pc_en", bus_a.pc_en, 0);
    tick();
    tick();
    chk("h_cycle_frozen", cyc_a, 1);
    br_mispred = 1;
    #1;
    chk("hb_halted", bus_a.halted, 0);
    chk("hb_ifid_flush", bus_a.ifid_flush, 1);
    chk("hb_idex_flush", bus_a.idex_flush, 1);
    chk("hb_pc_en", bus_a.pc_en, 1);
    tick();
    br_mispred = 0;
    #1;
    chk("hb_run_pc_en", bus_a.pc_en, 1);
    chk("hb_flush_cnt", fls_a, 1);
    halt = 1;
    tick();
    halt = 0; resume = 1;
    #1;
    chk("hr_halted", bus_a.halted, 1);
    tick();
    resume = 0;
    #1;
    chk("hr_run_halted", bus_a.halted, 0);
    chk("hr_run_pc_en", bus_a.pc_en, 1);

    // en=0 while dut_b is in FLUSH with one bubble left
    do_reset();
    en = 1; jmp = 1;
    tick();
    jmp = 0;
    tick();
    en = 0;
    #1;
    chk("en0_ifid_flush", bus_b.ifid_flush, 0);
    chk("en0_pc_en", bus_b.pc_en, 0);
    chk("en0_ifid_en", bus_b.ifid_en, 0);
    tick();
    tick();
    chk("en0_cycle_cnt", cyc_b, 2);
    chk("en0_flush_cnt", fls_b, 1);
    en = 1;
    #1;
    chk("en1_ifid_flush", bus_b.ifid_flush, 1);
    tick();
    chk("en1_done", bus_b.ifid_flush, 0);

    // Reset while halted
    do_reset();
    en = 1; halt = 1;
    tick();
    halt = 0;
    #1;
    chk("rh_halted", bus_a.halted, 1);
    rst = 0;
    #1;
    chk("rh_rst_halted", bus_a.halted, 0);
    chk("rh_rst_ifid_flush", bus_a.ifid_flush, 1);
    chk("rh_rst_idex_flush", bus_a.idex_flush, 1);
    chk("rh_rst_cyc", cyc_a, 0);
    en = 0;
    @(negedge clk);
    rst = 1;
    tick();
    en = 1;
    #1;
    chk("rh_run_pc_en", bus_a.pc_en, 1);
    chk("rh_run_halted", bus_a.halted, 0);

    // Saturation of the 4-bit counter
    do_reset();
    en = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_b_15", cyc_b, 15);
    chk("sat_a_20", cyc_a, 20);
    tick();
    tick();
    chk("sat_b_hold", cyc_b, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
